// File: rtl/byte_to_symbol_serializer.sv
// Byte-to-symbol serializer: takes one PSDU byte and emits it one bit at a
// time as two 4-bit symbols (low nibble first, LSB first). outSel carries the
// bit index inside the current symbol so a downstream 1:4 demux can steer
// each bit to its lane. Each bit is held for CYCLES_PER_BIT clocks.
module byte_to_symbol_serializer #(
  parameter int CYCLES_PER_BIT = 1
) (
  input  logic       inClk,
  input  logic       inRst,
  input  logic [7:0] inByte,
  input  logic       inValid,
  input  logic       inFlush,
  output logic       outReady,
  output logic       outData,
  output logic [1:0] outSel,
  output logic       outValid,
  output logic       outSymDone,
  output logic       outBusy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2
  } state_t;

  // Terminal value of the per-bit hold counter.
  localparam logic [7:0] HOLD_LAST = 8'(CYCLES_PER_BIT - 1);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;      // latched byte, shifted right as bits go out
  logic [1:0] bit_q, bit_d;    // bit index inside the active nibble
  logic [7:0] hold_q, hold_d;  // cycles the current bit has been held

  logic active;
  logic last_hold;
  logic sym_end;

  assign active    = (state_q != IDLE);
  assign last_hold = (hold_q == HOLD_LAST);
  assign sym_end   = active && last_hold && (bit_q == 2'd3);

  // Output decode; a flush in the same cycle cancels a pending symbol-done.
  always_comb begin
    outReady   = (state_q == IDLE) && !inFlush;
    outValid   = active;
    outBusy    = active;
    outData    = active ? sr_q[0] : 1'b0;
    outSel     = active ? bit_q : 2'd0;
    outSymDone = sym_end && !inFlush;
  end

  // Next-state logic: accept in IDLE, advance the bit on the last hold cycle,
  // move LO -> HI -> IDLE at each symbol end; flush overrides everything.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    if (inFlush) begin
      state_d = IDLE;
      sr_d    = 8'd0;
      bit_d   = 2'd0;
      hold_d  = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (inValid) begin
            state_d = SHIFT_LO;
            sr_d    = inByte;
            bit_d   = 2'd0;
            hold_d  = 8'd0;
          end
        end
        SHIFT_LO, SHIFT_HI: begin
          if (last_hold) begin
            hold_d = 8'd0;
            sr_d   = {1'b0, sr_q[7:1]};
            bit_d  = bit_q + 2'd1;
            if (bit_q == 2'd3) begin
              state_d = (state_q == SHIFT_LO) ? SHIFT_HI : IDLE;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          sr_d    = 8'd0;
          bit_d   = 2'd0;
          hold_d  = 8'd0;
        end
      endcase
    end
  end

  // State and datapath registers; reset wins over flush and acceptance.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q <= IDLE;
      sr_q    <= 8'd0;
      bit_q   <= 2'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_byte_to_symbol_serializer.sv
// Directed bench for byte_to_symbol_serializer: one instance with one cycle
// per bit and one with three cycles per bit share the same stimulus.
module tb_byte_to_symbol_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_flush;

  logic       r1, d1, v1, sd1, b1;
  logic [1:0] s1;
  logic       r3, d3, v3, sd3, b3;
  logic [1:0] s3;

  int n_chk  = 0;
  int n_fail = 0;

  byte_to_symbol_serializer #(.CYCLES_PER_BIT(1)) dut1 (
    .inClk(clk), .inRst(rst), .inByte(in_byte), .inValid(in_valid),
    .inFlush(in_flush), .outReady(r1), .outData(d1), .outSel(s1),
    .outValid(v1), .outSymDone(sd1), .outBusy(b1)
  );

  byte_to_symbol_serializer #(.CYCLES_PER_BIT(3)) dut3 (
    .inClk(clk), .inRst(rst), .inByte(in_byte), .inValid(in_valid),
    .inFlush(in_flush), .outReady(r3), .outData(d3), .outSel(s3),
    .outValid(v3), .outSymDone(sd3), .outBusy(b3)
  );

  // Advance to just after the next rising edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset is released.
  task automatic do_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    in_byte  = 8'h00;
    next_cycle;
    next_cycle;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    n_chk++;
    if ({v1, b1, sd1, d1, s1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs_cpb1: got %b expected 000000", {v1, b1, sd1, d1, s1});
    end
    n_chk++;
    if (r1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_cpb1: got %b expected 1", r1);
    end
    n_chk++;
    if ({v3, b3, sd3, d3, s3} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs_cpb3: got %b expected 000000", {v3, b3, sd3, d3, s3});
    end
    n_chk++;
    if (r3 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_cpb3: got %b expected 1", r3);
    end
  endtask

  // 0xA5 with one cycle per bit: bits 1,0,1,0,0,1,0,1, symbol ends at 4 and 8.
  task automatic test_basic_a5;
    logic [7:0] b;
    logic [3:0] exp;
    b = 8'hA5;
    do_reset;
    in_byte  = b;
    in_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (r1 !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_ready_c0: got %b expected 1", r1);
    end
    next_cycle;
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp = {1'b1, b[c-1], 2'((c - 1) % 4)};
      n_chk++;
      if ({v1, d1, s1} !== exp) begin
        n_fail++;
        $display("FAIL a5_stream c%0d: got v/d/sel %b expected %b", c, {v1, d1, s1}, exp);
      end
      n_chk++;
      if (sd1 !== ((c == 4) || (c == 8))) begin
        n_fail++;
        $display("FAIL a5_symdone c%0d: got %b expected %b", c, sd1, (c == 4) || (c == 8));
      end
      n_chk++;
      if ({r1, b1} !== 2'b01) begin
        n_fail++;
        $display("FAIL a5_ready_busy c%0d: got %b expected 01", c, {r1, b1});
      end
      next_cycle;
    end
    @(negedge clk);
    n_chk++;
    if ({r1, v1, b1, d1, s1} !== 6'b100000) begin
      n_fail++;
      $display("FAIL a5_idle_c9: got %b expected 100000", {r1, v1, b1, d1, s1});
    end
  endtask

  // 0x0F with three cycles per bit: ones for 12 cycles, zeros for 12.
  task automatic test_hold_cpb3;
    logic [3:0] exp;
    do_reset;
    in_byte  = 8'h0F;
    in_valid = 1'b1;
    next_cycle;
    in_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp = {1'b1, (c <= 12), 2'(((c - 1) / 3) % 4)};
      n_chk++;
      if ({v3, d3, s3} !== exp) begin
        n_fail++;
        $display("FAIL cpb3_stream c%0d: got v/d/sel %b expected %b", c, {v3, d3, s3}, exp);
      end
      n_chk++;
      if ({sd3, b3} !== {((c == 12) || (c == 24)), 1'b1}) begin
        n_fail++;
        $display("FAIL cpb3_symdone_busy c%0d: got %b expected %b", c, {sd3, b3},
                 {((c == 12) || (c == 24)), 1'b1});
      end
      next_cycle;
    end
    @(negedge clk);
    n_chk++;
    if ({b3, v3, r3} !== 3'b001) begin
      n_fail++;
      $display("FAIL cpb3_end_c25: got busy/valid/ready %b expected 001", {b3, v3, r3});
    end
  endtask

  // inValid held high: 0x12 at cycle 0, 0x34 only at cycle 9.
  task automatic test_back_to_back;
    logic [7:0] b;
    logic [3:0] exp;
    int         k;
    do_reset;
    in_byte  = 8'h12;
    in_valid = 1'b1;
    next_cycle;
    in_byte = 8'h34;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 9) begin
        n_chk++;
        if ({r1, v1} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_gap_c9: got ready/valid %b expected 10", {r1, v1});
        end
      end else begin
        b   = (c < 9) ? 8'h12 : 8'h34;
        k   = (c < 9) ? c - 1 : c - 10;
        exp = {1'b1, b[k], 2'(k % 4)};
        n_chk++;
        if ({v1, d1, s1} !== exp) begin
          n_fail++;
          $display("FAIL b2b_stream c%0d: got v/d/sel %b expected %b", c, {v1, d1, s1}, exp);
        end
        n_chk++;
        if ({r1, sd1} !== {1'b0, (k == 3) || (k == 7)}) begin
          n_fail++;
          $display("FAIL b2b_ready_symdone c%0d: got %b expected %b", c, {r1, sd1},
                   {1'b0, (k == 3) || (k == 7)});
        end
      end
      next_cycle;
      if (c == 9) in_valid = 1'b0;
    end
    @(negedge clk);
    n_chk++;
    if ({r1, v1} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_idle_c18: got ready/valid %b expected 10", {r1, v1});
    end
  endtask

  // Flush mid-nibble, then flush on the symbol-end cycle itself.
  task automatic test_flush;
    do_reset;
    in_byte  = 8'hFF;
    in_valid = 1'b1;
    next_cycle;
    in_valid = 1'b0;
    next_cycle;
    next_cycle;
    in_flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({r1, v1} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_c3: got ready/valid %b expected 01", {r1, v1});
    end
    next_cycle;
    in_flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({v1, sd1, r1, b1} !== 4'b0010) begin
      n_fail++;
      $display("FAIL flush_c4: got valid/symdone/ready/busy %b expected 0010", {v1, sd1, r1, b1});
    end
    in_valid = 1'b1;
    next_cycle;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) next_cycle;
    in_flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({v1, s1, sd1} !== 4'b1110) begin
      n_fail++;
      $display("FAIL flush_symdone_same_cycle: got valid/sel/symdone %b expected 1110", {v1, s1, sd1});
    end
    next_cycle;
    in_flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({v1, sd1, r1} !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_after_symend: got valid/symdone/ready %b expected 001", {v1, sd1, r1});
    end
    next_cycle;
    @(negedge clk);
    n_chk++;
    if ({v1, b1, d1} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_stays_idle: got %b expected 000", {v1, b1, d1});
    end
  endtask

  // Reset at cycle 6 of 0xC3 discards it; 0x01 then serializes cleanly.
  task automatic test_reset_mid;
    logic [7:0] b;
    logic [3:0] exp;
    do_reset;
    in_byte  = 8'hC3;
    in_valid = 1'b1;
    next_cycle;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) next_cycle;
    rst = 1'b1;
    next_cycle;
    rst      = 1'b0;
    b        = 8'h01;
    in_byte  = b;
    in_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({v1, b1, sd1, d1, s1} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_outs_c7: got %b expected 000000", {v1, b1, sd1, d1, s1});
    end
    n_chk++;
    if (r1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready_c7: got %b expected 1", r1);
    end
    next_cycle;
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp = {1'b1, b[c], 2'(c % 4)};
      n_chk++;
      if ({v1, d1, s1} !== exp) begin
        n_fail++;
        $display("FAIL rstmid_stream bit%0d: got v/d/sel %b expected %b", c, {v1, d1, s1}, exp);
      end
      n_chk++;
      if (sd1 !== ((c == 3) || (c == 7))) begin
        n_fail++;
        $display("FAIL rstmid_symdone bit%0d: got %b expected %b", c, sd1, (c == 3) || (c == 7));
      end
      next_cycle;
    end
  endtask

  // Flush and valid together in IDLE: not accepted; accepted one cycle later.
  task automatic test_flush_with_valid;
    do_reset;
    in_byte  = 8'h5A;
    in_valid = 1'b1;
    in_flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fv_ready_blocked: got %b expected 0", r1);
    end
    next_cycle;
    in_flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({v1, r1} !== 2'b01) begin
      n_fail++;
      $display("FAIL fv_not_accepted: got valid/ready %b expected 01", {v1, r1});
    end
    next_cycle;
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({v1, d1, s1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fv_bit0: got v/d/sel %b expected 1000", {v1, d1, s1});
    end
    next_cycle;
    @(negedge clk);
    n_chk++;
    if ({v1, d1, s1} !== 4'b1101) begin
      n_fail++;
      $display("FAIL fv_bit1: got v/d/sel %b expected 1101", {v1, d1, s1});
    end
  endtask

  initial begin
    test_reset;
    test_basic_a5;
    test_hold_cpb3;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_flush_with_valid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
